// File: rtl/xbus_sram_responder.sv
// Single-port XBUS SRAM target: byte-lane writes, registered-read storage,
// configurable wait states and out-of-range error reporting.
module xbus_sram_responder #(
   parameter logic [31:0] BASE        = 32'h0000_0000,
   parameter int          AW          = 10,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        xbus_req,
   input  logic        xbus_we,
   input  logic [3:0]  xbus_be,
   input  logic [31:0] xbus_addr,
   input  logic [31:0] xbus_wdata,
   output logic [31:0] xbus_rdata,
   output logic        xbus_ready,
   output logic        xbus_err
);

   localparam int          DEPTH = 1 << AW;
   localparam logic [32:0] SPAN  = 33'd1 << (AW + 2);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   logic [31:0] offset;
   logic        in_range;
   logic [AW-1:0] in_idx;
   logic        accept;

   logic [AW-1:0] idx_reg;
   logic        we_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic        range_reg;
   logic [3:0]  wait_cnt_reg;
   logic [31:0] rdata_hold_reg;

   logic        resp_active;
   logic        wr_commit;
   logic [AW-1:0] rd_idx;
   logic [31:0] mem_word;

   // The 33-bit compare keeps the window correct even when BASE+span wraps.
   assign offset   = xbus_addr - BASE;
   assign in_range = (xbus_addr >= BASE) && ({1'b0, offset} < SPAN);
   assign in_idx   = offset[AW+1:2];
   assign accept   = (state_reg == IDLE) && xbus_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (xbus_req) begin
               state_next = (WS != 4'd0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (wait_cnt_reg <= 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Gating with rst keeps a reset that lands in RESP from leaking a pulse or a write.
   always_comb begin
      resp_active = (state_reg == RESP) && !rst;
      xbus_ready  = resp_active;
      xbus_err    = resp_active && !range_reg;
      wr_commit   = resp_active && we_reg && range_reg;
      xbus_rdata  = rdata_hold_reg;
      if (resp_active && !we_reg) begin
         xbus_rdata = range_reg ? mem_word : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg        <= '0;
         we_reg         <= 1'b0;
         be_reg         <= 4'h0;
         wdata_reg      <= 32'h0;
         range_reg      <= 1'b0;
         wait_cnt_reg   <= 4'd0;
         rdata_hold_reg <= 32'h0;
      end else begin
         if (accept) begin
            idx_reg      <= in_idx;
            we_reg       <= xbus_we;
            be_reg       <= xbus_be;
            wdata_reg    <= xbus_wdata;
            range_reg    <= in_range;
            wait_cnt_reg <= WS;
         end else if ((state_reg == WAIT) && (wait_cnt_reg != 4'd0)) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
         end
         if (resp_active && !we_reg) begin
            rdata_hold_reg <= xbus_rdata;
         end
      end
   end

   // In IDLE the array is addressed from the bus so a zero-wait read has data in RESP;
   // afterwards the latched index keeps the read port on the accepted word.
   assign rd_idx = (state_reg == IDLE) ? in_idx : idx_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] q_reg;

         always_ff @(posedge clk) begin
            if (wr_commit && be_reg[gi]) begin
               mem[idx_reg] <= wdata_reg[8*gi +: 8];
            end
            q_reg <= mem[rd_idx];
         end

         assign mem_word[8*gi +: 8] = q_reg;
      end
   endgenerate

endmodule

// File: tb/tb_xbus_sram_responder.sv
// Scoreboard bench for xbus_sram_responder: three instances with different
// wait-state / base / depth settings, checked against a word-array model.
module tb_xbus_sram_responder;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0000;
   localparam logic [31:0] BASE2 = 32'h0000_1000;
   localparam int AW0 = 10;
   localparam int AW1 = 4;
   localparam int AW2 = 4;
   localparam int WS0 = 1;
   localparam int WS1 = 3;
   localparam int WS2 = 0;

   logic        clk = 1'b0;
   logic [2:0]  rst = 3'b111;
   logic [2:0]  req = 3'b000;
   logic [2:0]  we  = 3'b000;
   logic [3:0]  be    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic [2:0]  ready;
   logic [2:0]  err;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   xbus_sram_responder #(.BASE(BASE0), .AW(AW0), .WAIT_STATES(WS0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .xbus_req(req[0]), .xbus_we(we[0]), .xbus_be(be[0]),
      .xbus_addr(addr[0]), .xbus_wdata(wdata[0]), .xbus_rdata(rdata[0]),
      .xbus_ready(ready[0]), .xbus_err(err[0]));

   xbus_sram_responder #(.BASE(BASE1), .AW(AW1), .WAIT_STATES(WS1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .xbus_req(req[1]), .xbus_we(we[1]), .xbus_be(be[1]),
      .xbus_addr(addr[1]), .xbus_wdata(wdata[1]), .xbus_rdata(rdata[1]),
      .xbus_ready(ready[1]), .xbus_err(err[1]));

   xbus_sram_responder #(.BASE(BASE2), .AW(AW2), .WAIT_STATES(WS2)) u_dut2 (
      .clk(clk), .rst(rst[2]), .xbus_req(req[2]), .xbus_we(we[2]), .xbus_be(be[2]),
      .xbus_addr(addr[2]), .xbus_wdata(wdata[2]), .xbus_rdata(rdata[2]),
      .xbus_ready(ready[2]), .xbus_err(err[2]));

   typedef struct {
      int          k;
      bit          w;
      bit          e;
      logic [31:0] a;
      logic [31:0] d;
      int          at;
   } exp_t;

   exp_t        sbq [$];
   logic [31:0] mdl [int];
   logic [31:0] last_rd    [3];
   int          last_ready [3];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic int ws_of(input int k);
      case (k)
         0: return WS0;
         1: return WS1;
         default: return WS2;
      endcase
   endfunction

   function automatic int aw_of(input int k);
      case (k)
         0: return AW0;
         1: return AW1;
         default: return AW2;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int k);
      case (k)
         0: return BASE0;
         1: return BASE1;
         default: return BASE2;
      endcase
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endfunction

   // Monitor: every ready pulse must match the oldest expectation, in value and in time.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (!ready[k]) begin
            check("err_without_ready", 32'(err[k]), 32'h0);
         end else if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: instance %0d pulsed ready with no pending request (cycle %0d)", k, cyc);
         end else begin
            e = sbq.pop_front();
            check("instance", 32'(k), 32'(e.k));
            check("ready_cycle", 32'(cyc), 32'(e.at));
            check("err", 32'(err[k]), 32'(e.e));
            check("rdata", rdata[k], e.d);
            $display("txn inst=%0d %s addr=%h err=%0d rdata=%h cyc=%0d",
                     k, e.w ? "WR" : "RD", e.a, err[k], rdata[k], cyc);
         end
      end
   end

   task automatic do_reset(input int k, input int n);
      rst[k] = 1'b1;
      req[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reset_ready", 32'(ready[k]), 32'h0);
      check("reset_err", 32'(err[k]), 32'h0);
      check("reset_rdata", rdata[k], 32'h0);
      repeat (n - 1) @(posedge clk);
      #1;
      rst[k] = 1'b0;
      last_ready[k] = cyc - 1;
      last_rd[k] = 32'h0;
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input int k, input bit w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      longint      off;
      bit          inr;
      int          key;
      int          acc;
      bit          seen;
      logic [31:0] tmp;
      off = longint'({32'h0, a}) - longint'({32'h0, base_of(k)});
      inr = (off >= 0) && (off < (longint'(4) << aw_of(k)));
      key = inr ? (k * 65536 + int'(off >>> 2)) : 0;
      e.k = k;
      e.w = w;
      e.e = !inr;
      e.a = a;
      if (w) begin
         e.d = last_rd[k];
         if (inr) begin
            tmp = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int i = 0; i < 4; i++) begin
               if (b[i]) tmp[8*i +: 8] = d[8*i +: 8];
            end
            mdl[key] = tmp;
         end
      end else begin
         e.d = (inr && mdl.exists(key)) ? mdl[key] : 32'h0;
         last_rd[k] = e.d;
      end
      // Accepted at the next edge, but never before the IDLE cycle that follows a response.
      acc = (cyc + 1 > last_ready[k] + 2) ? cyc + 1 : last_ready[k] + 2;
      e.at = acc + ws_of(k);
      sbq.push_back(e);
      req[k] = 1'b1;
      we[k] = w;
      be[k] = b;
      addr[k] = a;
      wdata[k] = d;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ready[k]) seen = 1'b1;
         // Once accepted, scrambled inputs must not disturb the transaction.
         if (cyc >= acc) begin
            we[k] = 1'($urandom);
            be[k] = 4'($urandom);
            addr[k] = $urandom;
            wdata[k] = $urandom;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: instance %0d addr %h never returned ready", k, a);
         sbq.delete();
      end else begin
         last_ready[k] = cyc;
      end
      @(posedge clk);
      #1;
      req[k] = 1'b0;
   endtask

   task automatic rand_txn(input int k, input int nwin);
      logic [31:0] a;
      logic [31:0] base;
      int          sel;
      base = base_of(k);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
         case ($urandom_range(0, 2))
            0: a = base + (32'd4 << aw_of(k)) + 32'($urandom_range(0, 255));
            1: a = 32'hFFFF_FFFC;
            default: a = base - 32'd4;
         endcase
         if (a >= base && a - base < (32'd4 << aw_of(k))) a = base + (32'd4 << aw_of(k));
      end else begin
         a = base + 32'($urandom_range(0, nwin - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      end
      txn(k, 1'($urandom), 4'($urandom), a, $urandom);
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         be[k] = 4'h0;
         addr[k] = 32'h0;
         wdata[k] = 32'h0;
         last_rd[k] = 32'h0;
         last_ready[k] = -10;
      end
      repeat (2) @(posedge clk);
      #1;
      do_reset(0, 3);
      do_reset(1, 2);
      do_reset(2, 1);

      // Instance 0: one wait state, 1024 words at address 0.
      for (int i = 0; i < 1024; i++) txn(0, 1'b1, 4'hF, 32'(i * 4), $urandom);
      txn(0, 1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF);
      txn(0, 1'b0, 4'h0, 32'h8, 32'h0);
      txn(0, 1'b1, 4'b0010, 32'h9, 32'h0000_5500);
      txn(0, 1'b0, 4'hF, 32'h8, 32'h0);
      txn(0, 1'b1, 4'b0000, 32'h8, 32'hFFFF_FFFF);
      txn(0, 1'b0, 4'hF, 32'h8, 32'h0);
      txn(0, 1'b1, 4'b1100, 32'hA, 32'h1234_0000);
      txn(0, 1'b0, 4'hF, 32'hA, 32'h0);
      txn(0, 1'b0, 4'h1, 32'hB, 32'h0);
      txn(0, 1'b0, 4'hF, 32'h1000, 32'h0);
      txn(0, 1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D);
      txn(0, 1'b0, 4'hF, 32'h8, 32'h0);
      txn(0, 1'b1, 4'hF, 32'h1FFC, 32'h1111_2222);
      txn(0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
      txn(0, 1'b0, 4'hF, 32'hFFC, 32'h0);
      for (int i = 0; i < 200; i++) rand_txn(0, 16);
      for (int i = 0; i < 1024; i++) txn(0, 1'b0, 4'hF, 32'(i * 4), 32'h0);

      // Instance 1: three wait states; reset lands in the 2nd WAIT cycle of a write.
      for (int i = 0; i < 16; i++) txn(1, 1'b1, 4'hF, 32'(i * 4), $urandom);
      txn(1, 1'b0, 4'hF, 32'h20, 32'h0);
      begin
         int acc1;
         acc1 = (cyc + 1 > last_ready[1] + 2) ? cyc + 1 : last_ready[1] + 2;
         req[1] = 1'b1;
         we[1] = 1'b1;
         be[1] = 4'hF;
         addr[1] = 32'h14;
         wdata[1] = 32'hBAD0_BAD0;
         while (cyc < acc1 + 1) begin
            @(posedge clk);
            #1;
         end
         rst[1] = 1'b1;
         req[1] = 1'b0;
         @(posedge clk);
         #1;
         rst[1] = 1'b0;
         last_ready[1] = cyc - 1;
         last_rd[1] = 32'h0;
         repeat (8) @(posedge clk);
         #1;
      end
      txn(1, 1'b1, 4'hF, 32'h18, 32'h0F0F_0F0F);
      txn(1, 1'b0, 4'hF, 32'h14, 32'h0);
      for (int i = 0; i < 40; i++) rand_txn(1, 16);

      // Instance 2: zero wait states, base 0x1000; requests issued back to back.
      for (int i = 0; i < 16; i++) txn(2, 1'b1, 4'hF, 32'h1000 + 32'(i * 4), $urandom);
      txn(2, 1'b0, 4'hF, 32'h1000, 32'h0);
      txn(2, 1'b0, 4'hF, 32'h1004, 32'h0);
      txn(2, 1'b0, 4'hF, 32'h1008, 32'h0);
      txn(2, 1'b1, 4'b0101, 32'h1010, 32'hA5A5_A5A5);
      txn(2, 1'b0, 4'h0, 32'h1012, 32'h0);
      txn(2, 1'b0, 4'hF, 32'h0FFC, 32'h0);
      txn(2, 1'b0, 4'hF, 32'h1040, 32'h0);
      txn(2, 1'b0, 4'hF, 32'h103F, 32'h0);
      for (int i = 0; i < 60; i++) rand_txn(2, 16);

      repeat (4) @(posedge clk);
      check("scoreboard_empty", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
